move_ctrl_seq: RTL and testbench

- Parametrised hardware control sequencer for the datapath's move-from-special-register instructions (mfhi, mflo).
- Generates the step sequence T0 fetch-address, T1 memory read, T2 IR load, DEC decode, T3 execute. Drives the datapath's one-hot encoder-select, register-enable, incPC, read, Gra and Rin inputs.
- Sits beside datapath. Replaces hand-written per-instruction stimulus FSMs.
- Adds a start/done handshake, configurable step length, opcode-driven HI/LO selection, an illegal-opcode error and a continuous-run mode.

---
 rtl/move_ctrl_pkg.sv | 49 ++++
 rtl/move_ctrl_seq_if.sv | 36 +++
 rtl/step_timer.sv | 36 +++
 rtl/move_ctrl_seq.sv | 184 ++++++++++++++++++
 tb/tb_move_ctrl_seq.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_ctrl_pkg.sv
// move_ctrl_pkg: shared types and constants for the mfhi/mflo control sequencer.
//   state_e        : sequencer step enumeration
//   DEF_*          : default parameter values (bit indices, step length, opcodes)
//   OPC_*/RA_*     : instruction field positions within the IR
//   ir_opcode/ir_ra: field extraction helpers
package move_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_DEC  = 3'd4,
    S_T3   = 3'd5
  } state_e;

  localparam int unsigned IR_W  = 32;
  localparam int unsigned GRA_W = 4;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RA_MSB  = 26;
  localparam int unsigned RA_LSB  = 23;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Default datapath bit indices and timing
  localparam int unsigned DEF_ENC_W       = 32;
  localparam int unsigned DEF_STEP_CYCLES = 4;
  localparam int unsigned DEF_PC_IDX      = 20;
  localparam int unsigned DEF_MAR_IDX     = 23;
  localparam int unsigned DEF_ZLO_IDX     = 19;
  localparam int unsigned DEF_MDR_IDX     = 22;
  localparam int unsigned DEF_IR_IDX      = 21;
  localparam int unsigned DEF_HI_IDX      = 16;
  localparam int unsigned DEF_LO_IDX      = 17;

  localparam logic [OPC_W-1:0] DEF_OPC_MFHI = 5'b11001;
  localparam logic [OPC_W-1:0] DEF_OPC_MFLO = 5'b11010;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [IR_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [GRA_W-1:0] ir_ra(input logic [IR_W-1:0] ir);
    return ir[RA_MSB:RA_LSB];
  endfunction

endpackage

// File: rtl/move_ctrl_seq_if.sv
// move_ctrl_seq_if: handshake and datapath-control bundle of the sequencer.
//   start/cont/ir                 : control requests and IR contents into the sequencer
//   enc_input/reg_enable          : one-hot bus-source select and register load enables
//   incPC/read/Gra/Rin            : datapath strobes and register-file select
//   busy/done/err                 : sequencer status
// master = sequencer side, slave = datapath/requester side.
interface move_ctrl_seq_if
  import move_ctrl_pkg::*;
#(
  parameter int unsigned ENC_W = DEF_ENC_W
) ();

  logic             start;
  logic             cont;
  logic [IR_W-1:0]  ir;
  logic [ENC_W-1:0] enc_input;
  logic [ENC_W-1:0] reg_enable;
  logic             incPC;
  logic             read;
  logic [GRA_W-1:0] Gra;
  logic             Rin;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    input  start, cont, ir,
    output enc_input, reg_enable, incPC, read, Gra, Rin, busy, done, err
  );

  modport slave (
    output start, cont, ir,
    input  enc_input, reg_enable, incPC, read, Gra, Rin, busy, done, err
  );

endinterface

// File: rtl/step_timer.sv
// step_timer: remaining-cycle down-counter for one sequencer step.
//   i_clk, i_rst_n : clock, async active-low reset (counter clears to 0)
//   i_restart      : state is changing this edge; reload for a fresh step
//   o_last_c       : current cycle is the last of the step
//   o_last_nxt_c   : the cycle after the next edge will be the last of the step
module step_timer #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_last_c,
  output logic o_last_nxt_c
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count remaining cycles; saturate at 0 while a state lingers (IDLE)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= CNT_LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == '0);
  // A restart never lands on the last cycle because steps are at least 2 long
  assign o_last_nxt_c = !i_restart && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/move_ctrl_seq.sv
// move_ctrl_seq: control sequencer for mfhi/mflo (T0 fetch-addr, T1 read, T2 IR load,
// DEC decode, T3 execute). STEP_CYCLES must lie in 2..16.
//   clock : system clock, rising edge
//   clr   : asynchronous active-low reset, clears every output
//   bus   : move_ctrl_seq_if.master (start/cont/ir in; datapath controls and status out)
module move_ctrl_seq
  import move_ctrl_pkg::*;
#(
  parameter int unsigned       ENC_W       = DEF_ENC_W,
  parameter int unsigned       STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned       PC_IDX      = DEF_PC_IDX,
  parameter int unsigned       MAR_IDX     = DEF_MAR_IDX,
  parameter int unsigned       ZLO_IDX     = DEF_ZLO_IDX,
  parameter int unsigned       MDR_IDX     = DEF_MDR_IDX,
  parameter int unsigned       IR_IDX      = DEF_IR_IDX,
  parameter int unsigned       HI_IDX      = DEF_HI_IDX,
  parameter int unsigned       LO_IDX      = DEF_LO_IDX,
  parameter logic [OPC_W-1:0]  OPC_MFHI    = DEF_OPC_MFHI,
  parameter logic [OPC_W-1:0]  OPC_MFLO    = DEF_OPC_MFLO
) (
  input  logic            clock,
  input  logic            clr,
  move_ctrl_seq_if.master bus
);

  localparam logic [ENC_W-1:0] PC_BIT  = ENC_W'(1) << PC_IDX;
  localparam logic [ENC_W-1:0] MAR_BIT = ENC_W'(1) << MAR_IDX;
  localparam logic [ENC_W-1:0] ZLO_BIT = ENC_W'(1) << ZLO_IDX;
  localparam logic [ENC_W-1:0] MDR_BIT = ENC_W'(1) << MDR_IDX;
  localparam logic [ENC_W-1:0] IR_BIT  = ENC_W'(1) << IR_IDX;
  localparam logic [ENC_W-1:0] HI_BIT  = ENC_W'(1) << HI_IDX;
  localparam logic [ENC_W-1:0] LO_BIT  = ENC_W'(1) << LO_IDX;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_restart;
  logic             w_last;
  logic             w_last_nxt;

  logic [OPC_W-1:0] r_opcode;
  logic [GRA_W-1:0] r_ra;
  logic [OPC_W-1:0] w_opcode;
  logic [GRA_W-1:0] w_ra;
  logic             w_is_hi;
  logic             w_legal;

  logic [ENC_W-1:0] w_enc, r_enc;
  logic [ENC_W-1:0] w_ren, r_ren;
  logic             w_incpc, r_incpc;
  logic             w_read, r_read;
  logic [GRA_W-1:0] w_gra, r_gra;
  logic             w_rin, r_rin;
  logic             w_busy, r_busy;
  logic             w_done, r_done;
  logic             w_err, r_err;

  logic             w_unused_ir;
  assign w_unused_ir = ^bus.ir[RA_LSB-1:0];

  assign w_restart = (w_state_nxt != r_state);

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .i_clk        (clock),
    .i_rst_n      (clr),
    .i_restart    (w_restart),
    .o_last_c     (w_last),
    .o_last_nxt_c (w_last_nxt)
  );

  // Decode looks at the live IR during DEC so T3 controls can be registered on entry
  assign w_opcode = (r_state == S_DEC) ? ir_opcode(bus.ir) : r_opcode;
  assign w_ra     = (r_state == S_DEC) ? ir_ra(bus.ir)     : r_ra;
  assign w_is_hi  = (w_opcode == OPC_MFHI);
  assign w_legal  = w_is_hi || (w_opcode == OPC_MFLO);

  // State register
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_T0;
      S_T0:    if (w_last)    w_state_nxt = S_T1;
      S_T1:    if (w_last)    w_state_nxt = S_T2;
      S_T2:    if (w_last)    w_state_nxt = S_DEC;
      S_DEC:   w_state_nxt = w_legal ? S_T3 : S_IDLE;
      S_T3:    if (w_last)    w_state_nxt = bus.cont ? S_T0 : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computed for the upcoming state so registered outputs align with it
  always_comb begin
    w_enc   = '0;
    w_ren   = '0;
    w_incpc = 1'b0;
    w_read  = 1'b0;
    w_gra   = '0;
    w_rin   = 1'b0;
    w_busy  = (w_state_nxt != S_IDLE);
    w_done  = (r_state == S_T3) && w_last;
    w_err   = (r_state == S_DEC) && !w_legal;
    case (w_state_nxt)
      S_T0: begin
        w_enc = PC_BIT;
        if (w_last_nxt) begin
          w_ren   = MAR_BIT;
          w_incpc = 1'b1;
        end
      end
      S_T1: begin
        w_enc  = ZLO_BIT;
        w_read = 1'b1;
        if (w_last_nxt) w_ren = PC_BIT | MDR_BIT;
      end
      S_T2: begin
        w_enc = MDR_BIT;
        if (w_last_nxt) w_ren = IR_BIT;
      end
      S_T3: begin
        w_enc = w_is_hi ? HI_BIT : LO_BIT;
        w_gra = w_ra;
        w_rin = w_last_nxt;
      end
      default: ;
    endcase
  end

  // Opcode and ra capture at decode
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      r_opcode <= '0;
      r_ra     <= '0;
    end else if (r_state == S_DEC) begin
      r_opcode <= ir_opcode(bus.ir);
      r_ra     <= ir_ra(bus.ir);
    end
  end

  // Output registers
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      r_enc   <= '0;
      r_ren   <= '0;
      r_incpc <= 1'b0;
      r_read  <= 1'b0;
      r_gra   <= '0;
      r_rin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_enc   <= w_enc;
      r_ren   <= w_ren;
      r_incpc <= w_incpc;
      r_read  <= w_read;
      r_gra   <= w_gra;
      r_rin   <= w_rin;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign bus.enc_input  = r_enc;
  assign bus.reg_enable = r_ren;
  assign bus.incPC      = r_incpc;
  assign bus.read       = r_read;
  assign bus.Gra        = r_gra;
  assign bus.Rin        = r_rin;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_move_ctrl_seq.sv
// tb_move_ctrl_seq: two sequencer instances (STEP_CYCLES 4 and 2) driven in lockstep,
// compared every cycle against a position-in-instruction reference model.
module tb_move_ctrl_seq;

  localparam int unsigned ENC_W = 32;
  localparam int unsigned NA    = 4;
  localparam int unsigned NB    = 2;
  localparam int unsigned VW    = 2 * ENC_W + 10;
  localparam logic [4:0]  OPC_HI = 5'b11001;
  localparam logic [4:0]  OPC_LO = 5'b11010;
  localparam logic [31:0] IR_HI  = 32'hC900_0000;

  logic clock = 1'b0;
  logic clr_a;
  logic clr_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: position within the current instruction (0 = idle)
  int unsigned m_pos  [2];
  logic        m_hi   [2];
  logic [3:0]  m_ra   [2];
  logic        m_done [2];
  logic        m_err  [2];

  int obs_busy [2];
  int obs_done [2];
  int obs_err  [2];
  int obs_rin  [2];
  int obs_bit16_a;
  int obs_gra7_a;
  int last_done_a;
  int done_gap_a;

  always #5 clock = ~clock;

  move_ctrl_seq_if #(.ENC_W(ENC_W)) bus_a ();
  move_ctrl_seq_if #(.ENC_W(ENC_W)) bus_b ();

  move_ctrl_seq #(.ENC_W(ENC_W), .STEP_CYCLES(NA)) u_dut_a (
    .clock (clock),
    .clr   (clr_a),
    .bus   (bus_a)
  );

  move_ctrl_seq #(.ENC_W(ENC_W), .STEP_CYCLES(NB)) u_dut_b (
    .clock (clock),
    .clr   (clr_b),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int unsigned n_of(input int d);
    return (d == 0) ? NA : NB;
  endfunction

  function automatic logic [VW-1:0] obs_vec(input int d);
    if (d == 0)
      return {bus_a.enc_input, bus_a.reg_enable, bus_a.incPC, bus_a.read, bus_a.Gra,
              bus_a.Rin, bus_a.busy, bus_a.done, bus_a.err};
    return {bus_b.enc_input, bus_b.reg_enable, bus_b.incPC, bus_b.read, bus_b.Gra,
            bus_b.Rin, bus_b.busy, bus_b.done, bus_b.err};
  endfunction

  // Expected outputs from the position within an instruction of n-cycle steps
  function automatic logic [VW-1:0] model_vec(input int d);
    int unsigned      n   = n_of(d);
    int unsigned      pos = m_pos[d];
    int unsigned      st;
    int unsigned      off;
    logic [ENC_W-1:0] enc = '0;
    logic [ENC_W-1:0] ren = '0;
    logic             incpc = 1'b0;
    logic             rd    = 1'b0;
    logic [3:0]       gra   = '0;
    logic             rin   = 1'b0;
    if (pos >= 1 && pos <= 3 * n) begin
      st  = (pos - 1) / n;
      off = (pos - 1) % n;
      if (st == 0) begin
        enc[20] = 1'b1;
        if (off == n - 1) begin ren[23] = 1'b1; incpc = 1'b1; end
      end else if (st == 1) begin
        enc[19] = 1'b1;
        rd      = 1'b1;
        if (off == n - 1) begin ren[20] = 1'b1; ren[22] = 1'b1; end
      end else begin
        enc[22] = 1'b1;
        if (off == n - 1) ren[21] = 1'b1;
      end
    end else if (pos >= 3 * n + 2) begin
      off = pos - 3 * n - 2;
      enc[m_hi[d] ? 16 : 17] = 1'b1;
      gra = m_ra[d];
      rin = (off == n - 1);
    end
    return {enc, ren, incpc, rd, gra, rin, (pos != 0), m_done[d], m_err[d]};
  endfunction

  // Advance the model across one clock edge with the inputs about to be sampled
  task automatic model_step(input int d, input logic st, input logic ct, input logic [31:0] ir_v);
    int unsigned n = n_of(d);
    int unsigned p = m_pos[d];
    m_done[d] = 1'b0;
    m_err[d]  = 1'b0;
    if (p == 0) begin
      m_pos[d] = st ? 1 : 0;
    end else if (p == 3 * n + 1) begin
      if (ir_v[31:27] == OPC_HI || ir_v[31:27] == OPC_LO) begin
        m_hi[d]  = (ir_v[31:27] == OPC_HI);
        m_ra[d]  = ir_v[26:23];
        m_pos[d] = p + 1;
      end else begin
        m_err[d] = 1'b1;
        m_pos[d] = 0;
      end
    end else if (p == 4 * n + 1) begin
      m_done[d] = 1'b1;
      m_pos[d]  = ct ? 1 : 0;
    end else begin
      m_pos[d] = p + 1;
    end
  endtask

  task automatic model_reset(input int d);
    m_pos[d]  = 0;
    m_done[d] = 1'b0;
    m_err[d]  = 1'b0;
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      obs_busy[d] = 0; obs_done[d] = 0; obs_err[d] = 0; obs_rin[d] = 0;
    end
    obs_bit16_a = 0;
    obs_gra7_a  = 0;
    last_done_a = -1;
    done_gap_a  = 0;
  endtask

  // Drive inputs just after a falling edge, then compare at the next falling edge
  task automatic cycle(input logic st, input logic ct, input logic [31:0] ir_v);
    bus_a.start = st; bus_a.cont = ct; bus_a.ir = ir_v;
    bus_b.start = st; bus_b.cont = ct; bus_b.ir = ir_v;
    if (clr_a) model_step(0, st, ct, ir_v);
    if (clr_b) model_step(1, st, ct, ir_v);
    @(negedge clock);
    cyc++;
    check("dut_a", obs_vec(0), model_vec(0));
    check("dut_b", obs_vec(1), model_vec(1));
    obs_busy[0] += bus_a.busy ? 1 : 0;
    obs_busy[1] += bus_b.busy ? 1 : 0;
    obs_done[0] += bus_a.done ? 1 : 0;
    obs_done[1] += bus_b.done ? 1 : 0;
    obs_err[0]  += bus_a.err  ? 1 : 0;
    obs_err[1]  += bus_b.err  ? 1 : 0;
    obs_rin[0]  += bus_a.Rin  ? 1 : 0;
    obs_rin[1]  += bus_b.Rin  ? 1 : 0;
    obs_bit16_a += (bus_a.enc_input[16] || bus_a.reg_enable[16]) ? 1 : 0;
    obs_gra7_a  += (bus_a.Gra == 4'd7 && bus_a.enc_input[17]) ? 1 : 0;
    if (bus_a.done) begin
      if (last_done_a >= 0) done_gap_a = cyc - last_done_a;
      last_done_a = cyc;
    end
  endtask

  task automatic run_until_idle(input logic ct, input logic [31:0] ir_v, input int max_cyc);
    int k = 0;
    while ((m_pos[0] != 0 || m_pos[1] != 0) && k < max_cyc) begin
      cycle(1'b0, ct, ir_v);
      k++;
    end
    check("idle_reached", VW'({bus_a.busy, bus_b.busy}), VW'(0));
  endtask

  // Async reset between edges: outputs must clear before any clock edge
  task automatic mid_reset(input logic rst_a, input logic rst_b, input logic [31:0] ir_v);
    #2;
    if (rst_a) clr_a = 1'b0;
    if (rst_b) clr_b = 1'b0;
    #1;
    if (rst_a) begin model_reset(0); check("async_rst_a", obs_vec(0), VW'(0)); end
    if (rst_b) begin model_reset(1); check("async_rst_b", obs_vec(1), VW'(0)); end
    cycle(1'b0, 1'b0, ir_v);
    clr_a = 1'b1;
    clr_b = 1'b1;
  endtask

  initial begin
    logic [31:0] ir_lo;
    logic [31:0] ir_bad;
    logic [31:0] ir_r;
    int          k;

    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      m_hi[d] = 1'b0;
      m_ra[d] = '0;
    end
    clear_obs();
    clr_a = 1'b0;
    clr_b = 1'b0;

    // Reset held with start asserted: everything stays 0
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, IR_HI);

    // mfhi, start still held when reset releases
    clear_obs();
    clr_a = 1'b1;
    clr_b = 1'b1;
    cycle(1'b1, 1'b0, IR_HI);
    run_until_idle(1'b0, IR_HI, 60);
    check("mfhi_busy_a", VW'(obs_busy[0]), VW'(17));
    check("mfhi_done_a", VW'(obs_done[0]), VW'(1));
    check("mfhi_rin_a",  VW'(obs_rin[0]),  VW'(1));
    check("mfhi_busy_b", VW'(obs_busy[1]), VW'(9));

    // mflo, ra = 7
    ir_lo = {OPC_LO, 4'd7, 23'h12345};
    clear_obs();
    cycle(1'b1, 1'b0, ir_lo);
    run_until_idle(1'b0, ir_lo, 60);
    check("mflo_done_a",  VW'(obs_done[0]), VW'(1));
    check("mflo_no_bit16", VW'(obs_bit16_a), VW'(0));
    check("mflo_gra7_a",  VW'(obs_gra7_a),  VW'(NA));

    // Illegal opcode, with and without cont
    ir_bad = {5'b00000, 4'd3, 23'h0};
    clear_obs();
    cycle(1'b1, 1'b0, ir_bad);
    run_until_idle(1'b0, ir_bad, 60);
    check("bad_err_a",  VW'(obs_err[0]),  VW'(1));
    check("bad_done_a", VW'(obs_done[0]), VW'(0));
    check("bad_rin_a",  VW'(obs_rin[0]),  VW'(0));
    clear_obs();
    cycle(1'b1, 1'b1, ir_bad);
    run_until_idle(1'b1, ir_bad, 60);
    check("bad_cont_err_a",  VW'(obs_err[0]),  VW'(1));
    check("bad_cont_busy_a", VW'(obs_busy[0]), VW'(3 * NA + 1));

    // Continuous mode across two instructions, cont dropped during the second
    clear_obs();
    cycle(1'b1, 1'b1, IR_HI);
    k = 0;
    while (obs_done[0] == 0 && k < 60) begin
      cycle(1'b0, 1'b1, IR_HI);
      k++;
    end
    run_until_idle(1'b0, IR_HI, 100);
    check("cont_done_a", VW'(obs_done[0]), VW'(2));
    check("cont_gap_a",  VW'(done_gap_a),  VW'(17));
    check("cont_busy_a", VW'(obs_busy[0]), VW'(34));

    // Short-step instance reset on the second cycle of T1, then a clean restart
    cycle(1'b1, 1'b0, IR_HI);
    k = 0;
    while (m_pos[1] != NB + 2 && k < 10) begin
      cycle(1'b0, 1'b0, IR_HI);
      k++;
    end
    check("b_in_t1_read", VW'(bus_b.read), VW'(1));
    mid_reset(1'b0, 1'b1, IR_HI);
    run_until_idle(1'b0, IR_HI, 60);
    clear_obs();
    cycle(1'b1, 1'b0, IR_HI);
    run_until_idle(1'b0, IR_HI, 60);
    check("b_restart_busy", VW'(obs_busy[1]), VW'(9));
    check("b_restart_done", VW'(obs_done[1]), VW'(1));

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      ir_r = $urandom;
      k = int'($urandom_range(9));
      if (k < 4)      ir_r[31:27] = OPC_HI;
      else if (k < 8) ir_r[31:27] = OPC_LO;
      if ($urandom_range(399) == 0) begin
        mid_reset(1'b1, 1'b1, ir_r);
      end else begin
        cycle($urandom_range(3) == 0, $urandom_range(2) == 0, ir_r);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
